// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller and its predictor table.
package branch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t       CTR_RESET = 2'b01;
    localparam logic [31:0] PC_INCR   = 32'd4;

    // Saturating 2-bit counter step: count up on taken, down on not-taken.
    function automatic ctr2_t satUpdate(input ctr2_t ctr, input logic taken);
        ctr2_t result;
        result = ctr;
        if (taken) begin
            if (ctr != 2'b11) result = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) result = ctr - 2'b01;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_bht.sv
// Direction predictor table for branch_redirect_ctrl: 2^IDX_BITS saturating 2-bit counters.
// Instantiated by the top only when BRANCH_PRED_EN is defined.
module branch_bht
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookupPc_i,
    output logic        predTaken_o,
    input  logic        updateEn_i,
    input  logic [31:0] updatePc_i,
    input  logic        updateTaken_i
);

    localparam int ENTRIES = 1 << IDX_BITS;

    ctr2_t               counters_q [ENTRIES];
    logic [IDX_BITS-1:0] lookupIdx;
    logic [IDX_BITS-1:0] updateIdx;
    logic                unusedPcBits;

    assign lookupIdx = lookupPc_i[IDX_BITS+1:2];
    assign updateIdx = updatePc_i[IDX_BITS+1:2];

    // Reads see the pre-update value; a same-cycle write lands at the edge.
    assign predTaken_o = counters_q[lookupIdx][1];

    assign unusedPcBits = ^{lookupPc_i[31:IDX_BITS+2], lookupPc_i[1:0],
                            updatePc_i[31:IDX_BITS+2], updatePc_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counters_q[i] <= CTR_RESET;
            end
        end else if (updateEn_i) begin
            counters_q[updateIdx] <= satUpdate(counters_q[updateIdx], updateTaken_i);
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch resolution / pipeline redirect controller with statistics counters.
// Optional 2-bit direction predictor is built when BRANCH_PRED_EN is defined.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int BHT_IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        ex_take,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic        flush_if,
    output logic        flush_id,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int               CNT_W      = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        redirectPc_q, redirectPc_d;
    logic               redirectValid_q, redirectValid_d;
    logic               flush_q, flush_d;
    logic [31:0]        branchCnt_q, branchCnt_d;
    logic [31:0]        mispredCnt_q, mispredCnt_d;

    logic               idle;
    logic               branchEvt;
    logic               mispredEvt;
    logic               redirectEvt;
    logic [31:0]        redirectTarget;

    // Resolve events only count while IDLE; anything later is wrong-path.
    assign idle        = (state_q == IDLE);
    assign branchEvt   = idle & ex_valid & ex_is_branch;
    assign mispredEvt  = branchEvt & (ex_take != ex_pred_taken);
    assign redirectEvt = mispredEvt | (idle & ex_valid & ex_is_jump);

    assign redirectTarget = (ex_is_jump | ex_take) ? ex_target : (ex_pc + PC_INCR);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        redirectPc_d = redirectPc_q;
        branchCnt_d  = branchCnt_q;
        mispredCnt_d = mispredCnt_q;

        case (state_q)
            IDLE: begin
                if (redirectEvt) begin
                    state_d      = REDIRECT;
                    redirectPc_d = redirectTarget;
                end
            end
            REDIRECT: begin
                if (redirectValid_q && redirect_ready) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (branchEvt)  branchCnt_d  = branchCnt_q + 32'd1;
        if (mispredEvt) mispredCnt_d = mispredCnt_q + 32'd1;

        // Outputs are flopped from the next state so they are glitch-free registers.
        redirectValid_d = (state_d == REDIRECT);
        flush_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            redirectPc_q    <= '0;
            redirectValid_q <= 1'b0;
            flush_q         <= 1'b0;
            branchCnt_q     <= '0;
            mispredCnt_q    <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            redirectPc_q    <= redirectPc_d;
            redirectValid_q <= redirectValid_d;
            flush_q         <= flush_d;
            branchCnt_q     <= branchCnt_d;
            mispredCnt_q    <= mispredCnt_d;
        end
    end

    assign redirect_valid = redirectValid_q;
    assign redirect_pc    = redirectPc_q;
    assign flush_if       = flush_q;
    assign flush_id       = flush_q;
    assign branch_cnt     = branchCnt_q;
    assign mispred_cnt    = mispredCnt_q;

`ifdef BRANCH_PRED_EN
    branch_bht #(
        .IDX_BITS (BHT_IDX_BITS)
    ) u_bht (
        .clk           (clk),
        .rst           (rst),
        .lookupPc_i    (if_pc),
        .predTaken_o   (if_pred_taken),
        .updateEn_i    (branchEvt),
        .updatePc_i    (ex_pc),
        .updateTaken_i (ex_take)
    );
`else
    logic unusedIfPc;

    assign if_pred_taken = 1'b0;
    assign unusedIfPc    = ^{if_pc, BHT_IDX_BITS[0]};
`endif

endmodule
